// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS run controller and debug unit:
// state encoding, host command bytes and protocol widths.
package mips_dbg_pkg;

   localparam int BYTE_W  = 8;
   localparam int WORD_W  = 32;
   localparam int STATE_W = 3;

   localparam logic [BYTE_W-1:0] DBG_CMD_RUN    = 8'h31;
   localparam logic [BYTE_W-1:0] DBG_CMD_STEP   = 8'h32;
   localparam logic [BYTE_W-1:0] DBG_CMD_RELOAD = 8'h33;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CMD   = 3'd3,
      RUN   = 3'd4,
      STEP  = 3'd5,
      DUMP  = 3'd6
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs bytes MSB-first into a 32-bit word; word_valid flags the load
// that completes the fourth byte.
module word_assembler
   import mips_dbg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= {word[WORD_W-BYTE_W-1:0], byte_in};
         cnt  <= cnt + 2'd1;
      end
   end

   assign word_valid = load && (cnt == 2'd3);

endmodule

// File: rtl/mips_run_controller.sv
// Run-control sequencer: loads a program from the UART into program memory,
// then runs/steps the core via a clock-enable and requests a state dump.
module mips_run_controller
   import mips_dbg_pkg::*;
#(
   parameter int              ADDR_W         = 5,
   parameter int              MAX_RUN_CYCLES = 65535,
   parameter logic [BYTE_W-1:0] CMD_RUN      = DBG_CMD_RUN,
   parameter logic [BYTE_W-1:0] CMD_STEP     = DBG_CMD_STEP,
   parameter logic [BYTE_W-1:0] CMD_RELOAD   = DBG_CMD_RELOAD
)(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               I_RX_EMPTY,
   input  logic [BYTE_W-1:0]  I_RX_DATA,
   output logic               O_RD_UART,
   output logic               O_PM_WR,
   output logic [ADDR_W-1:0]  O_PM_ADDR,
   output logic [WORD_W-1:0]  O_PM_DATA,
   output logic               O_MIPS_EN,
   output logic               O_MIPS_RESET,
   input  logic               I_MIPS_FINISHED,
   output logic               O_DUMP_REQ,
   input  logic               I_DUMP_DONE,
   output logic [31:0]        O_CYCLES,
   output logic               O_ERR,
   output logic               O_TIMEOUT,
   output logic [STATE_W-1:0] O_STATE
);

   localparam int          CNT_W       = ADDR_W + 1;
   localparam logic [31:0] MAX_WORDS   = 32'(1 << ADDR_W);
   localparam logic [31:0] RUN_LIMIT   = 32'(MAX_RUN_CYCLES);

   state_t              state, next_state;
   logic [CNT_W-1:0]    n_words;
   logic [ADDR_W-1:0]   word_idx;
   logic [31:0]         run_cnt;
   logic [WORD_W-1:0]   word;
   logic                word_valid;
   logic                len_ok, last_word, run_limit;
   logic                asm_clear, asm_load;

   assign len_ok    = (I_RX_DATA != '0) && (32'(I_RX_DATA) <= MAX_WORDS);
   assign last_word = ({1'b0, word_idx} == n_words - CNT_W'(1));
   assign run_limit = (run_cnt + 32'd1 == RUN_LIMIT);
   assign asm_clear = (state == IDLE) && O_RD_UART && len_ok;
   assign asm_load  = (state == RECV) && O_RD_UART;

   word_assembler u_asm (
      .clk        (CLK),
      .reset      (RESET),
      .clear      (asm_clear),
      .load       (asm_load),
      .byte_in    (I_RX_DATA),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (O_RD_UART && len_ok) next_state = RECV;
         RECV:  if (word_valid) next_state = WRITE;
         WRITE: next_state = last_word ? CMD : RECV;
         CMD: begin
            if (O_RD_UART) begin
               case (I_RX_DATA)
                  CMD_RUN:    next_state = RUN;
                  CMD_STEP:   next_state = STEP;
                  CMD_RELOAD: next_state = IDLE;
                  default:    next_state = CMD;
               endcase
            end
         end
         RUN:   if (I_MIPS_FINISHED || run_limit) next_state = DUMP;
         STEP:  next_state = DUMP;
         DUMP:  if (I_DUMP_DONE) next_state = CMD;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      O_RD_UART = 1'b0;
      O_PM_WR   = 1'b0;
      O_MIPS_EN = 1'b0;
      case (state)
         IDLE, RECV, CMD: O_RD_UART = !I_RX_EMPTY;
         WRITE:           O_PM_WR   = 1'b1;
         RUN, STEP:       O_MIPS_EN = !I_MIPS_FINISHED;
         default: ;
      endcase
   end

   assign O_STATE   = state;
   assign O_PM_ADDR = word_idx;
   assign O_PM_DATA = word;

   // Core reset and cycle-counter clear both happen on the WRITE->CMD edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         n_words      <= '0;
         word_idx     <= '0;
         run_cnt      <= '0;
         O_CYCLES     <= '0;
         O_ERR        <= 1'b0;
         O_TIMEOUT    <= 1'b0;
         O_MIPS_RESET <= 1'b0;
         O_DUMP_REQ   <= 1'b0;
      end else begin
         O_MIPS_RESET <= (state == WRITE) && last_word;
         O_DUMP_REQ   <= (next_state == DUMP) && (state != DUMP);

         if (state == IDLE && O_RD_UART) begin
            if (len_ok) begin
               n_words  <= CNT_W'(I_RX_DATA);
               word_idx <= '0;
               O_ERR    <= 1'b0;
            end else begin
               O_ERR    <= 1'b1;
            end
         end

         if (state == WRITE && !last_word) word_idx <= word_idx + ADDR_W'(1);

         if (state != RUN)   run_cnt <= '0;
         else if (O_MIPS_EN) run_cnt <= run_cnt + 32'd1;

         if (state == RUN && !I_MIPS_FINISHED && run_limit) O_TIMEOUT <= 1'b1;

         if (state == WRITE && last_word)         O_CYCLES <= '0;
         else if (O_MIPS_EN && O_CYCLES != '1)    O_CYCLES <= O_CYCLES + 32'd1;
      end
   end

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller with a transaction-level model
// checked every cycle, plus literal checks on key scenario results.
module tb_mips_run_controller;
   import mips_dbg_pkg::*;

   localparam int ADDR_W = 5;
   localparam int MAXRUN = 16;
   localparam int BIG    = 1 << 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_empty = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        fin = 1'b0;
   logic        done = 1'b0;
   logic        rd_uart, pm_wr, mips_en, mips_reset, dump_req, err, timeout;
   logic [ADDR_W-1:0] pm_addr;
   logic [31:0] pm_data, cycles;
   logic [2:0]  state;

   mips_run_controller #(.ADDR_W(ADDR_W), .MAX_RUN_CYCLES(MAXRUN)) dut (
      .CLK(clk), .RESET(reset), .I_RX_EMPTY(rx_empty), .I_RX_DATA(rx_data),
      .O_RD_UART(rd_uart), .O_PM_WR(pm_wr), .O_PM_ADDR(pm_addr), .O_PM_DATA(pm_data),
      .O_MIPS_EN(mips_en), .O_MIPS_RESET(mips_reset), .I_MIPS_FINISHED(fin),
      .O_DUMP_REQ(dump_req), .I_DUMP_DONE(done), .O_CYCLES(cycles),
      .O_ERR(err), .O_TIMEOUT(timeout), .O_STATE(state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit chk_on = 0;

   // environment: RX FIFO contents, core halting after core_target enabled cycles
   logic [7:0]  rx_q[$];
   int          core_cnt = 0, core_target = BIG;
   int          en_count = 0, rst_count = 0, dreq_count = 0;
   logic [31:0] wr_addr[$], wr_data[$];

   // model
   state_t      m_st = IDLE;
   int          m_n = 0, m_widx = 0, m_run = 0;
   logic [7:0]  m_bytes[$];
   logic [31:0] m_cycles = 0;
   bit          m_err = 0, m_to = 0, m_rst = 0, m_dreq = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_rd();
      return !rx_empty && (m_st == IDLE || m_st == RECV || m_st == CMD);
   endfunction

   function automatic logic exp_en();
      return (m_st == RUN || m_st == STEP) && !fin;
   endfunction

   function automatic logic [31:0] exp_word();
      if (m_bytes.size() != 4) return 32'h0;
      return {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
   endfunction

   task automatic model_step();
      logic pop, en;
      int   bi;
      pop = exp_rd();
      en  = exp_en();
      bi  = int'(rx_data);
      if (reset) begin
         m_st = IDLE; m_n = 0; m_widx = 0; m_run = 0; m_bytes.delete();
         m_cycles = 0; m_err = 0; m_to = 0; m_rst = 0; m_dreq = 0;
         return;
      end
      m_rst = 0;
      m_dreq = 0;
      if (en && m_cycles != 32'hFFFF_FFFF) m_cycles++;
      case (m_st)
         IDLE: if (pop) begin
            if (bi >= 1 && bi <= (1 << ADDR_W)) begin
               m_n = bi; m_widx = 0; m_bytes.delete(); m_err = 0; m_st = RECV;
            end else m_err = 1;
         end
         RECV: if (pop) begin
            m_bytes.push_back(rx_data);
            if (m_bytes.size() == 4) m_st = WRITE;
         end
         WRITE: begin
            m_bytes.delete();
            if (m_widx == m_n - 1) begin m_st = CMD; m_rst = 1; m_cycles = 0; end
            else begin m_widx++; m_st = RECV; end
         end
         CMD: if (pop) begin
            if (bi == 'h31) begin m_st = RUN; m_run = 0; end
            else if (bi == 'h32) m_st = STEP;
            else if (bi == 'h33) m_st = IDLE;
         end
         RUN: if (fin) begin m_st = DUMP; m_dreq = 1; end
         else begin
            m_run++;
            if (m_run == MAXRUN) begin m_to = 1; m_st = DUMP; m_dreq = 1; end
         end
         STEP: begin m_st = DUMP; m_dreq = 1; end
         DUMP: if (done) m_st = CMD;
         default: m_st = IDLE;
      endcase
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("rd_uart", 32'(rd_uart), 32'(exp_rd()));
         chk("pm_wr", 32'(pm_wr), 32'(m_st == WRITE));
         if (m_st == WRITE) begin
            chk("pm_addr", 32'(pm_addr), 32'(m_widx));
            chk("pm_data", pm_data, exp_word());
         end
         chk("mips_en", 32'(mips_en), 32'(exp_en()));
         chk("mips_reset", 32'(mips_reset), 32'(m_rst));
         chk("dump_req", 32'(dump_req), 32'(m_dreq));
         chk("cycles", cycles, m_cycles);
         chk("err", 32'(err), 32'(m_err));
         chk("timeout", 32'(timeout), 32'(m_to));
         chk("state", 32'(state), 32'(m_st));
      end
   end

   task automatic drive_rx();
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rx_q[0];
   endtask

   task automatic push(input logic [7:0] b);
      rx_q.push_back(b);
      drive_rx();
   endtask

   task automatic tick();
      logic p, e;
      @(negedge clk);
      p = rd_uart;
      e = mips_en;
      if (pm_wr) begin wr_addr.push_back(32'(pm_addr)); wr_data.push_back(pm_data); end
      if (mips_reset) rst_count++;
      if (dump_req) dreq_count++;
      if (e) en_count++;
      @(posedge clk);
      model_step();
      #1;
      if (p && rx_q.size() != 0) rx_q.delete(0);
      if (e) core_cnt++;
      fin = (core_cnt >= core_target);
      drive_rx();
   endtask

   task automatic wait_state(input state_t s, input int budget, input string name);
      int n = 0;
      while (state !== s && n < budget) begin tick(); n++; end
      chk(name, 32'(state), 32'(s));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (rx_q.size() != 0 && n < 100) begin tick(); n++; end
      chk(name, 32'(rx_q.size()), 32'd0);
   endtask

   task automatic fresh_core();
      core_cnt = 0;
      core_target = BIG;
      fin = 1'b0;
   endtask

   task automatic dump_ack();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("dump_to_cmd", 32'(state), 32'(CMD));
   endtask

   logic [7:0] load2[9] = '{8'd2, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

   initial begin
      drive_rx();
      repeat (3) tick();
      reset = 1'b0;
      chk_on = 1;
      chk("rst_state", 32'(state), 32'(IDLE));
      chk("rst_cycles", cycles, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_pm_addr", 32'(pm_addr), 32'd0);
      chk("rst_pm_data", pm_data, 32'd0);

      // length errors
      push(8'd0); drain("drain_n0");
      chk("n0_err", 32'(err), 32'd1);
      chk("n0_idle", 32'(state), 32'(IDLE));
      push(8'd1); drain("drain_n1");
      chk("n1_err_clear", 32'(err), 32'd0);
      chk("n1_recv", 32'(state), 32'(RECV));
      push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
      wait_state(CMD, 30, "n1_cmd");
      push(8'h33); wait_state(IDLE, 10, "reload_idle");
      push(8'd33); drain("drain_n33");
      chk("n33_err", 32'(err), 32'd1);
      chk("n33_idle", 32'(state), 32'(IDLE));

      // two-word load
      wr_addr.delete(); wr_data.delete(); rst_count = 0;
      foreach (load2[i]) push(load2[i]);
      wait_state(CMD, 40, "load_cmd");
      tick();
      chk("load_wr_count", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         chk("load_addr0", wr_addr[0], 32'd0);
         chk("load_data0", wr_data[0], 32'h2008_0005);
         chk("load_addr1", wr_addr[1], 32'd1);
         chk("load_data1", wr_data[1], 32'h0000_000C);
      end
      chk("load_rst_pulses", 32'(rst_count), 32'd1);
      chk("load_err_clear", 32'(err), 32'd0);

      // run: core halts after 10 enabled cycles
      en_count = 0; dreq_count = 0; core_cnt = 0; core_target = 10; fin = 1'b0;
      push(8'h31);
      wait_state(DUMP, 100, "run_dump");
      chk("run_en_count", 32'(en_count), 32'd10);
      chk("run_cycles", cycles, 32'd10);
      repeat (50) tick();
      chk("dump_wait", 32'(state), 32'(DUMP));
      chk("run_dreq_count", 32'(dreq_count), 32'd1);
      dump_ack();

      // three steps after a fresh load
      push(8'h33); wait_state(IDLE, 10, "reload2_idle");
      fresh_core();
      push(8'd1); push(8'h24); push(8'h02); push(8'h00); push(8'h07);
      wait_state(CMD, 30, "load3_cmd");
      tick();
      en_count = 0; rst_count = 0;
      for (int k = 0; k < 3; k++) begin
         push(8'h32);
         wait_state(DUMP, 20, "step_dump");
         dump_ack();
      end
      tick();
      chk("step_en_count", 32'(en_count), 32'd3);
      chk("step_cycles", cycles, 32'd3);
      chk("step_no_reset", 32'(rst_count), 32'd0);

      // watchdog; a byte arriving during DUMP must stay queued
      en_count = 0;
      push(8'h31);
      wait_state(DUMP, 100, "wd_dump");
      chk("wd_en_count", 32'(en_count), 32'd16);
      chk("wd_timeout", 32'(timeout), 32'd1);
      chk("wd_cycles", cycles, 32'd19);
      push(8'h78);
      repeat (5) tick();
      chk("dump_no_pop", 32'(rx_q.size()), 32'd1);
      dump_ack();
      repeat (2) tick();
      chk("unknown_popped", 32'(rx_q.size()), 32'd0);
      chk("unknown_stay_cmd", 32'(state), 32'(CMD));

      // reset after 6 of 8 load bytes
      push(8'h33); wait_state(IDLE, 10, "reload3_idle");
      for (int k = 0; k < 7; k++) push(load2[k]);
      drain("drain_partial");
      chk("partial_recv", 32'(state), 32'(RECV));
      wr_addr.delete(); wr_data.delete();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("midload_reset_idle", 32'(state), 32'(IDLE));
      chk("midload_timeout_clr", 32'(timeout), 32'd0);
      repeat (3) tick();
      chk("midload_no_wr", 32'(wr_addr.size()), 32'd0);
      fresh_core();
      push(8'd1); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      wait_state(CMD, 30, "reload_cmd");
      tick();
      chk("reload_wr_count", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         chk("reload_addr", wr_addr[0], 32'd0);
         chk("reload_data", wr_data[0], 32'h1122_3344);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Run-control sequencer for the pipelined MIPS core.
- Takes program bytes from the UART RX FIFO, packs them into 32-bit words and writes them to program memory.
- Decodes host commands (run / step / reload) and drives a clock-enable to the core instead of a gated clock.
- After each run or step, asks the debug unit for a state dump and waits for it to finish.

Parameters:
ADDR_W, 5, program-memory word-address width; capacity MAX_WORDS = 2^ADDR_W
MAX_RUN_CYCLES, 65535, RUN watchdog limit in enabled core cycles
CMD_RUN, 8'h31, ASCII '1'
CMD_STEP, 8'h32, ASCII '2'
CMD_RELOAD, 8'h33, ASCII '3'

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
I_RX_EMPTY  in  1  UART RX FIFO empty
I_RX_DATA  in  8  RX FIFO head byte, valid when I_RX_EMPTY=0
O_RD_UART  out  1  one-cycle pop of RX FIFO head
O_PM_WR  out  1  program-memory write strobe
O_PM_ADDR  out  ADDR_W  program-memory word address
O_PM_DATA  out  32  program-memory write data
O_MIPS_EN  out  1  core clock-enable
O_MIPS_RESET  out  1  one-cycle core pipeline reset
I_MIPS_FINISHED  in  1  core has retired its halt instruction
O_DUMP_REQ  out  1  one-cycle request to debug unit
I_DUMP_DONE  in  1  debug unit finished transmitting
O_CYCLES  out  32  enabled core cycles since last O_MIPS_RESET; saturates at all-ones
O_ERR  out  1  sticky length error
O_TIMEOUT  out  1  sticky watchdog expiry
O_STATE  out  3  current state encoding, for debug

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all strobes 0; O_PM_ADDR=0; O_PM_DATA=0; O_CYCLES=0; O_ERR=0; O_TIMEOUT=0.
- Pop rule: O_RD_UART = !I_RX_EMPTY while in IDLE, RECV or CMD; 0 in all other states. A byte is consumed in the cycle it is popped.
- IDLE: popped byte is N, the word count.
  - 1<=N<=MAX_WORDS: latch N, clear word index and byte count, clear O_ERR, go to RECV.
  - N=0 or N>MAX_WORDS: set O_ERR, stay in IDLE.
- RECV: shift each popped byte into a 32-bit assembly register, MSB first (the first byte lands in [31:24]). A 2-bit byte counter wraps at 4. On the 4th byte, go to WRITE.
- WRITE (1 cycle):
  - O_PM_WR=1, O_PM_ADDR=word index, O_PM_DATA=assembled word.
  - If word index == N-1: go to CMD and pulse O_MIPS_RESET for 1 cycle (it coincides with the first CMD cycle). Otherwise increment the word index and return to RECV.
- CMD: decode each popped byte.
  - CMD_RUN: go to RUN.
  - CMD_STEP: go to STEP.
  - CMD_RELOAD: go to IDLE.
  - Any other byte: discarded, stay in CMD.
- RUN:
  - O_MIPS_EN = !I_MIPS_FINISHED (combinational); O_CYCLES increments on every enabled cycle.
  - Exit to DUMP on the cycle I_MIPS_FINISHED=1.
  - If the run counter reaches MAX_RUN_CYCLES: set O_TIMEOUT and exit to DUMP.
  - If I_MIPS_FINISHED is already 1 on entry: zero enabled cycles.
- STEP (1 cycle): O_MIPS_EN = !I_MIPS_FINISHED, then DUMP.
- DUMP:
  - O_DUMP_REQ=1 on the entry cycle only.
  - Wait for I_DUMP_DONE; on the cycle it is sampled high, go to CMD. I_DUMP_DONE in any other state is ignored.
- O_MIPS_RESET pulses only on WRITE->CMD. Consequences:
  - RELOAD followed by a new load restarts the core.
  - Repeated RUN/STEP without a reload continues from the current core state.
  - O_CYCLES clears on the same cycle as O_MIPS_RESET.
- The RX FIFO is never popped outside IDLE/RECV/CMD. Bytes that arrive during RUN/STEP/DUMP stay queued.
- RESET asserted in any state, mid-load or mid-run, returns to IDLE at the next edge. Partial words are discarded and program memory is not written.

Decomposition:
- Shared package mips_dbg_pkg holds: state encoding (IDLE, RECV, WRITE, CMD, RUN, STEP, DUMP), the CMD_* byte constants, and the protocol widths; the debug unit uses the same package.
- One natural sub-module: word_assembler (byte shift register plus 2-bit counter, with load/clear and a word_valid output).
- The FSM, counters and watchdog live in the top of this block.

Test Plan:
- Load: N=2, then bytes 20 08 00 05 | 00 00 00 0C.
  - Expect O_PM_WR at addr 0 with 32'h20080005, then at addr 1 with 32'h0000000C.
  - Expect a one-cycle O_MIPS_RESET, then state CMD.
- Length errors: N=0 -> O_ERR=1, stay in IDLE. N=MAX_WORDS+1 (33) -> O_ERR=1. A following valid N=1 clears O_ERR.
- Run: after a load, send '1' with I_MIPS_FINISHED rising after 10 enabled cycles.
  - Expect exactly 10 O_MIPS_EN cycles, O_CYCLES=10 and one O_DUMP_REQ pulse.
  - Hold I_DUMP_DONE low 50 cycles: state stays DUMP. Raise it: back to CMD.
- Step: send '2' three times with a dump completing between each. Expect O_MIPS_EN high exactly 1 cycle per step, O_CYCLES=3, no O_MIPS_RESET.
- Watchdog: MAX_RUN_CYCLES=16, I_MIPS_FINISHED held 0, send '1'. Expect 16 enabled cycles, O_TIMEOUT=1, then DUMP.
- Reset and unknown bytes:
  - Assert RESET after 6 of 8 load bytes: state IDLE, no further O_PM_WR. A re-load succeeds.
  - In CMD, byte 'x' (8'h78) is popped and ignored; state stays CMD.
